// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - IF stage: PC/IR registers and req/ready fetch from a variable-latency imem
// A fetch that sees no imem_ready within TIMEOUT request cycles loads NOP_INST and latches a sticky fault.
module inst_fetch_unit #(
  parameter int unsigned        ADDR_W   = 16,
  parameter int unsigned        INST_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [ADDR_W-1:0]  PC_STEP  = ADDR_W'(1),
  parameter logic [INST_W-1:0]  NOP_INST = '0,
  parameter logic [3:0]         LD_OPC   = 4'h7,
  parameter logic [3:0]         ST_OPC   = 4'h8,
  parameter int unsigned        TIMEOUT  = 15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ir_wen,
  input  logic              i_pc_wen,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ready,
  input  logic [INST_W-1:0] i_imem_rdata,
  output logic [ADDR_W-1:0] o_pc,
  output logic [INST_W-1:0] o_ir,
  output logic              o_mem_inst,
  output logic              o_fetch_busy,
  output logic              o_fetch_fault
);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_ir;
  logic [7:0]        r_count;
  logic              r_fault;
  logic              w_timeout;
  logic [3:0]        w_opcode;

  assign w_timeout = (r_count == 8'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (i_ir_wen) w_next_state = S_REQ;
      S_REQ:  if (i_imem_ready || w_timeout) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // req and busy come straight off the state flop, so both are registered outputs
  always_comb begin
    o_imem_req   = 1'b0;
    o_fetch_busy = 1'b0;
    if (r_state == S_REQ) begin
      o_imem_req   = 1'b1;
      o_fetch_busy = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc    <= RESET_PC;
      r_ir    <= NOP_INST;
      r_count <= '0;
      r_fault <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (i_pc_wen) begin
        r_pc <= i_branch_taken ? i_branch_target : r_pc + PC_STEP;
      end
      if (i_ir_wen) begin
        r_count <= '0;
      end
    end else begin
      // ready takes priority over an expiring timeout
      if (i_imem_ready) begin
        r_ir <= i_imem_rdata;
      end else if (w_timeout) begin
        r_ir    <= NOP_INST;
        r_fault <= 1'b1;
      end else begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign w_opcode      = r_ir[INST_W-1 -: 4];
  assign o_mem_inst    = (w_opcode == LD_OPC) || (w_opcode == ST_OPC);
  assign o_imem_addr   = r_pc;
  assign o_pc          = r_pc;
  assign o_ir          = r_ir;
  assign o_fetch_fault = r_fault;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed and randomized bench for inst_fetch_unit against a transaction-level model
module tb_inst_fetch_unit;

  localparam int TIMEOUT = 15;

  logic        clk;
  logic        reset;
  logic        ir_wen;
  logic        pc_wen;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] pc;
  logic [15:0] ir;
  logic        mem_inst;
  logic        fetch_busy;
  logic        fetch_fault;

  inst_fetch_unit dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_ir_wen        (ir_wen),
    .i_pc_wen        (pc_wen),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .o_imem_req      (imem_req),
    .o_imem_addr     (imem_addr),
    .i_imem_ready    (imem_ready),
    .i_imem_rdata    (imem_rdata),
    .o_pc            (pc),
    .o_ir            (ir),
    .o_mem_inst      (mem_inst),
    .o_fetch_busy    (fetch_busy),
    .o_fetch_fault   (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a fetch is "pending" from the accepting edge until ready or the TIMEOUT-th request cycle ends
  logic [15:0] m_pc;
  logic [15:0] m_ir;
  bit          m_fault;
  bit          m_pend;
  int          m_waited;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 16'h0; m_ir = 16'h0; m_fault = 0; m_pend = 0; m_waited = 0;
    end else if (m_pend) begin
      m_waited = m_waited + 1;
      if (imem_ready) begin
        m_ir = imem_rdata; m_pend = 0;
      end else if (m_waited == TIMEOUT) begin
        m_ir = 16'h0; m_fault = 1; m_pend = 0;
      end
    end else begin
      if (pc_wen) m_pc = branch_taken ? branch_target : 16'(m_pc + 16'd1);
      if (ir_wen) begin m_pend = 1; m_waited = 0; end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_req",   imem_req,    m_pend);
      check("cyc_busy",  fetch_busy,  m_pend);
      check("cyc_addr",  imem_addr,   m_pc);
      check("cyc_pc",    pc,          m_pc);
      check("cyc_ir",    ir,          m_ir);
      check("cyc_fault", fetch_fault, m_fault);
      check("cyc_mem",   mem_inst,    (m_ir[15:12] == 4'h7) || (m_ir[15:12] == 4'h8));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ir_wen = 0; pc_wen = 0; branch_taken = 0; branch_target = '0;
    imem_ready = 0; imem_rdata = '0;
  endtask

  bit dead_mem;

  initial begin
    reset = 1; idle_inputs();
    cyc(); cyc();
    reset = 0;
    check_en = 1;
    check("rst_pc", pc, 16'h0);
    check("rst_ir", ir, 16'h0);
    check("rst_req", imem_req, 1'b0);
    check("rst_busy", fetch_busy, 1'b0);
    check("rst_fault", fetch_fault, 1'b0);
    check("rst_mem", mem_inst, 1'b0);

    // zero-wait fetch
    ir_wen = 1; cyc(); ir_wen = 0;
    check("t1_req", imem_req, 1'b1);
    check("t1_addr", imem_addr, 16'h0);
    check("t1_busy", fetch_busy, 1'b1);
    imem_ready = 1; imem_rdata = 16'h7123; cyc(); imem_ready = 0;
    check("t1_ir", ir, 16'h7123);
    check("t1_busy_end", fetch_busy, 1'b0);
    check("t1_mem", mem_inst, 1'b1);

    // three wait cycles
    ir_wen = 1; cyc(); ir_wen = 0;
    for (int i = 0; i < 3; i++) begin
      check("t2_busy_wait", fetch_busy, 1'b1);
      check("t2_addr_wait", imem_addr, 16'h0);
      cyc();
    end
    check("t2_busy_last", fetch_busy, 1'b1);
    imem_ready = 1; imem_rdata = 16'h1234; cyc(); imem_ready = 0;
    check("t2_ir", ir, 16'h1234);
    check("t2_mem", mem_inst, 1'b0);
    check("t2_busy_end", fetch_busy, 1'b0);

    // timeout
    ir_wen = 1; cyc(); ir_wen = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      check("t3_req_hold", imem_req, 1'b1);
      cyc();
    end
    check("t3_req_drop", imem_req, 1'b0);
    check("t3_ir_nop", ir, 16'h0);
    check("t3_fault", fetch_fault, 1'b1);
    ir_wen = 1; cyc(); ir_wen = 0;
    imem_ready = 1; imem_rdata = 16'h8abc; cyc(); imem_ready = 0;
    check("t3_refetch_ir", ir, 16'h8abc);
    check("t3_fault_sticky", fetch_fault, 1'b1);

    // PC wrap, branch, pc_wen during REQ, combined pc_wen+ir_wen
    pc_wen = 1; branch_taken = 1; branch_target = 16'hFFFF; cyc();
    check("t4_pc_max", pc, 16'hFFFF);
    branch_taken = 0; cyc();
    check("t4_pc_wrap", pc, 16'h0);
    branch_taken = 1; branch_target = 16'h0040; cyc();
    pc_wen = 0; branch_taken = 0;
    check("t4_pc_branch", pc, 16'h0040);
    ir_wen = 1; cyc(); ir_wen = 0;
    pc_wen = 1; branch_taken = 1; branch_target = 16'h1111; cyc();
    pc_wen = 0; branch_taken = 0;
    check("t4_pc_req_hold", pc, 16'h0040);
    imem_ready = 1; imem_rdata = 16'h0001; cyc(); imem_ready = 0;
    check("t4_pc_after", pc, 16'h0040);
    pc_wen = 1; ir_wen = 1; cyc(); pc_wen = 0; ir_wen = 0;
    check("t4_addr_newpc", imem_addr, 16'h0041);
    imem_ready = 1; imem_rdata = 16'h0002; cyc(); imem_ready = 0;

    // ir_wen during REQ is ignored
    ir_wen = 1; cyc();
    check("t5_req", imem_req, 1'b1);
    cyc(); ir_wen = 0;
    imem_ready = 1; imem_rdata = 16'h2222; cyc(); imem_ready = 0;
    check("t5_ir", ir, 16'h2222);
    check("t5_req_off", imem_req, 1'b0);
    cyc();
    check("t5_no_second_req", imem_req, 1'b0);

    // reset mid-REQ, late ready ignored
    ir_wen = 1; cyc(); ir_wen = 0;
    cyc();
    check("t6_req_2nd", imem_req, 1'b1);
    reset = 1; cyc(); reset = 0;
    imem_ready = 1; imem_rdata = 16'h7777;
    check("t6_req_low", imem_req, 1'b0);
    cyc(); imem_ready = 0;
    check("t6_ir_nop", ir, 16'h0);
    check("t6_pc_reset", pc, 16'h0);
    check("t6_req_still_low", imem_req, 1'b0);
    check("t6_fault_cleared", fetch_fault, 1'b0);

    // randomized phase, checked every cycle by the model comparison
    dead_mem = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) dead_mem = ($urandom_range(0, 2) == 0);
      reset         = ($urandom_range(0, 299) == 0);
      ir_wen        = ($urandom_range(0, 3) == 0);
      pc_wen        = ($urandom_range(0, 3) == 0);
      branch_taken  = $urandom_range(0, 1);
      branch_target = 16'($urandom);
      imem_ready    = !dead_mem && ($urandom_range(0, 3) == 0);
      imem_rdata    = 16'($urandom);
      cyc();
    end
    reset = 0; idle_inputs();
    cyc();
    check_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
